// File: rtl/fk_pkg.sv
// rtl/fk_pkg.sv - shared constants and result-entry type for the forwardk scheduler
//
// Purpose: fixed-point format constants, default datapath latency and the
//          {id, x, y} result-entry layout used around the forwardk datapath.
// Ports:   none (package).
package fk_pkg;

  localparam int          FK_WIDTH       = 32;
  localparam int          FK_FRAC        = 15;
  localparam int          FK_LAT_DEFAULT = 5;
  localparam logic [31:0] FK_ONE         = 32'h0000_8000;
  localparam logic [31:0] FK_HALF        = 32'h0000_4000;
  localparam int          FK_ID_W        = 8;

  typedef struct packed {
    logic [FK_ID_W-1:0]  id;
    logic [FK_WIDTH-1:0] x;
    logic [FK_WIDTH-1:0] y;
  } fk_entry_t;

endpackage

// File: rtl/fk_sched_fifo.sv
// rtl/fk_sched_fifo.sv - synchronous result FIFO for the forwardk scheduler
//
// Purpose: DEPTH-entry FIFO; push and pop in the same cycle are both honoured,
//          including when full (the popped slot is reused by the push).
// Ports:   clk, rst       clock, synchronous active-high reset
//          i_push, i_data write strobe and entry
//          i_pop          read strobe (ignored when empty)
//          o_data         head entry, 0 when empty
//          o_full, o_empty, o_count  occupancy status
module fk_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int EW    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [EW-1:0]                i_data,
  input  logic                         i_pop,
  output logic [EW-1:0]                o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_data    = o_empty ? '0 : r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= ptr_inc(r_wr);
      if (w_do_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/fk_sched.sv
// rtl/fk_sched.sv - round-robin scheduler sharing one forwardk datapath
//
// Purpose: arbitrates NREQ requesters onto a fixed-latency datapath, tracks
//          in-flight operations with a tag pipeline and returns results in
//          issue order through a credit-protected FIFO.
// Ports:   clk, rst                    clock, synchronous active-high reset
//          req_valid/req_ready         per-requester handshake (one-hot ready)
//          req_theta1/req_theta2       packed per-requester angles
//          fk_theta1_o/fk_theta2_o     registered angles to the datapath
//          fk_x_i/fk_y_i               datapath results
//          resp_valid/resp_ready       result handshake
//          resp_id/resp_x/resp_y       result entry at the FIFO head
//          perf_issued/stall/bp        saturating counters (FK_SCHED_PERF_EN only)
//          busy                        operation in flight or FIFO non-empty
// Build option: FK_SCHED_PERF_EN adds the performance counters.
module fk_sched import fk_pkg::*; #(
  parameter  int NREQ   = 2,
  parameter  int WIDTH  = FK_WIDTH,
  parameter  int FK_LAT = FK_LAT_DEFAULT,
  parameter  int DEPTH  = 4,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_theta1,
  input  logic [NREQ*WIDTH-1:0] req_theta2,
  output logic [WIDTH-1:0]      fk_theta1_o,
  output logic [WIDTH-1:0]      fk_theta2_o,
  input  logic [WIDTH-1:0]      fk_x_i,
  input  logic [WIDTH-1:0]      fk_y_i,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_x,
  output logic [WIDTH-1:0]      resp_y,
`ifdef FK_SCHED_PERF_EN
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stall,
  output logic [31:0]           perf_bp,
`endif
  output logic                  busy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = IDW + 2*WIDTH;

  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] w_win;
  logic           w_any;
  logic           w_issue;
  logic           r_iss_v;
  logic [IDW-1:0] r_iss_id;
  logic [FK_LAT-1:0] r_tag_v;
  logic [IDW-1:0] r_tag_id [FK_LAT];
  // Credits held = operations in flight + entries in the FIFO.
  logic [CW-1:0]  r_used;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_fifo_cnt;
  logic [EW-1:0]  w_head;

  // First valid requester at or after r_rr_ptr: scan offsets downwards so the
  // smallest offset is the last one written.
  always_comb begin : p_arb
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        w_any = 1'b1;
        w_win = IDW'(idx);
      end
    end
  end

  assign w_issue = w_any && !rst && (r_used < CW'(DEPTH));

  always_comb begin
    req_ready = '0;
    if (w_issue) req_ready[w_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      fk_theta1_o <= '0;
      fk_theta2_o <= '0;
      r_iss_v     <= 1'b0;
      r_iss_id    <= '0;
      r_tag_v     <= '0;
      r_used      <= '0;
      for (int i = 0; i < FK_LAT; i++) r_tag_id[i] <= '0;
    end else begin
      fk_theta1_o <= w_issue ? req_theta1[w_win*WIDTH +: WIDTH] : '0;
      fk_theta2_o <= w_issue ? req_theta2[w_win*WIDTH +: WIDTH] : '0;
      r_iss_v     <= w_issue;
      r_iss_id    <= w_win;
      if (w_issue) r_rr_ptr <= (int'(w_win) == NREQ-1) ? '0 : w_win + 1'b1;
      // Tag stage 0 follows the cycle the angles sit on fk_theta*_o, so the
      // last stage lines up with fk_x_i/fk_y_i FK_LAT cycles later.
      r_tag_v[0]  <= r_iss_v;
      r_tag_id[0] <= r_iss_id;
      for (int i = 1; i < FK_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
      case ({w_issue, w_pop})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end

  assign w_push = r_tag_v[FK_LAT-1];
  assign w_pop  = resp_valid && resp_ready;

  fk_sched_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_tag_id[FK_LAT-1], fk_x_i, fk_y_i}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_cnt)
  );

  assign resp_valid = !w_empty;
  assign resp_id    = w_head[EW-1 -: IDW];
  assign resp_x     = w_head[2*WIDTH-1 -: WIDTH];
  assign resp_y     = w_head[WIDTH-1:0];
  assign busy       = (r_used != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full && !w_pop));
  a_credit_cover: assert property (@(posedge clk) disable iff (rst)
    w_fifo_cnt <= r_used);

`ifdef FK_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_bp     <= '0;
    end else begin
      if (w_issue && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
      if (w_any && !w_issue && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      if (resp_valid && !resp_ready && perf_bp != '1) perf_bp <= perf_bp + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fk_sched.sv
// tb/tb_fk_sched.sv - self-checking bench for fk_sched
module tb_fk_sched;
  import fk_pkg::*;

  localparam int NREQ   = 2;
  localparam int WIDTH  = 32;
  localparam int FK_LAT = 5;
  localparam int DEPTH  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_theta1;
  logic [NREQ*WIDTH-1:0] req_theta2;
  logic [WIDTH-1:0]      fk_theta1_o;
  logic [WIDTH-1:0]      fk_theta2_o;
  logic [WIDTH-1:0]      fk_x_i;
  logic [WIDTH-1:0]      fk_y_i;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [0:0]            resp_id;
  logic [WIDTH-1:0]      resp_x;
  logic [WIDTH-1:0]      resp_y;
  logic                  busy;
`ifdef FK_SCHED_PERF_EN
  logic [31:0]           perf_issued;
  logic [31:0]           perf_stall;
  logic [31:0]           perf_bp;
`endif

  always #5 clk = ~clk;

  fk_sched #(
    .NREQ(NREQ), .WIDTH(WIDTH), .FK_LAT(FK_LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_theta1(req_theta1), .req_theta2(req_theta2),
    .fk_theta1_o(fk_theta1_o), .fk_theta2_o(fk_theta2_o),
    .fk_x_i(fk_x_i), .fk_y_i(fk_y_i),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_x(resp_x), .resp_y(resp_y),
`ifdef FK_SCHED_PERF_EN
    .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_bp(perf_bp),
`endif
    .busy(busy)
  );

  // Stand-in datapath: x = 1.0 + t1 - t2, y = t1 + t2, FK_LAT cycles deep.
  function automatic logic [31:0] f_x(input logic [31:0] t1, input logic [31:0] t2);
    return FK_ONE + t1 - t2;
  endfunction
  function automatic logic [31:0] f_y(input logic [31:0] t1, input logic [31:0] t2);
    return t1 + t2;
  endfunction

  logic [WIDTH-1:0] dp_x [FK_LAT];
  logic [WIDTH-1:0] dp_y [FK_LAT];
  always @(posedge clk) begin
    dp_x[0] <= f_x(fk_theta1_o, fk_theta2_o);
    dp_y[0] <= f_y(fk_theta1_o, fk_theta2_o);
    for (int i = 1; i < FK_LAT; i++) begin
      dp_x[i] <= dp_x[i-1];
      dp_y[i] <= dp_y[i-1];
    end
  end
  assign fk_x_i = dp_x[FK_LAT-1];
  assign fk_y_i = dp_y[FK_LAT-1];

  // Reference model: outstanding results in issue order with the cycle each
  // becomes visible, round-robin pointer, expected angle outputs, counters.
  fk_entry_t  q_ent[$];
  int         q_rdy[$];
  int         rr_m, cyc, n_cmp, n_bad;
  logic [31:0] exp_t1, exp_t2;
  int         m_issued, m_stall, m_bp;

  logic            obs_rv, obs_hs, obs_busy;
  logic [NREQ-1:0] obs_ready;
  logic [0:0]      obs_id;
  logic [31:0]     obs_x, obs_y;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; checks this cycle and
  // advances across the next posedge.
  task automatic cycle_check();
    int win;
    bit any, exp_rv;
    logic [NREQ-1:0] exp_ready;
    logic [31:0] t1, t2;
    fk_entry_t e;
    #1;
    obs_rv = resp_valid; obs_ready = req_ready; obs_hs = |(req_valid & req_ready);
    obs_id = resp_id; obs_x = resp_x; obs_y = resp_y; obs_busy = busy;
    any = (req_valid != '0);
    win = -1;
    if (!rst && any && q_ent.size() < DEPTH)
      for (int k = 0; k < NREQ; k++)
        if (win < 0 && req_valid[(rr_m + k) % NREQ]) win = (rr_m + k) % NREQ;
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    exp_rv = (q_rdy.size() > 0) && (q_rdy[0] <= cyc);
    chk("req_ready", req_ready, exp_ready);
    chk("resp_valid", resp_valid, exp_rv);
    chk("busy", busy, q_ent.size() > 0);
    chk("fk_theta1_o", fk_theta1_o, exp_t1);
    chk("fk_theta2_o", fk_theta2_o, exp_t2);
    if (exp_rv) begin
      chk("resp_id", resp_id, q_ent[0].id);
      chk("resp_x", resp_x, q_ent[0].x);
      chk("resp_y", resp_y, q_ent[0].y);
    end
`ifdef FK_SCHED_PERF_EN
    chk("perf_issued", perf_issued, m_issued);
    chk("perf_stall", perf_stall, m_stall);
    chk("perf_bp", perf_bp, m_bp);
`endif
    if (rst) begin
      q_ent.delete(); q_rdy.delete();
      rr_m = 0; exp_t1 = '0; exp_t2 = '0;
      m_issued = 0; m_stall = 0; m_bp = 0;
    end else begin
      if (any && win < 0) m_stall++;
      if (exp_rv && !resp_ready) m_bp++;
      if (exp_rv && resp_ready) begin
        void'(q_ent.pop_front());
        void'(q_rdy.pop_front());
      end
      exp_t1 = '0; exp_t2 = '0;
      if (win >= 0) begin
        t1 = req_theta1[win*WIDTH +: WIDTH];
        t2 = req_theta2[win*WIDTH +: WIDTH];
        e.id = 8'(win); e.x = f_x(t1, t2); e.y = f_y(t1, t2);
        q_ent.push_back(e);
        q_rdy.push_back(cyc + FK_LAT + 2);
        rr_m = (win + 1) % NREQ;
        m_issued++;
        exp_t1 = t1; exp_t2 = t2;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle_check();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0; resp_ready = 1'b1;
    while (q_ent.size() > 0 && n < 100) begin cycle_check(); n++; end
    cycle_check();
    chk("drain_bound", n < 100, 1);
  endtask

  task automatic single_req(input int id, input logic [31:0] t1, input logic [31:0] t2,
                            input logic [31:0] ex, input logic [31:0] ey);
    int lat;
    req_valid = '0; req_valid[id] = 1'b1;
    req_theta1[id*WIDTH +: WIDTH] = t1;
    req_theta2[id*WIDTH +: WIDTH] = t2;
    resp_ready = 1'b1;
    cycle_check();
    chk("sr_handshake", obs_hs, 1);
    req_valid = '0;
    lat = 0;
    do begin
      cycle_check();
      if (!obs_rv) lat++;
    end while (!obs_rv && lat < 40);
    chk("sr_latency", lat, FK_LAT + 1);
    chk("sr_id", obs_id, id);
    chk("sr_x", obs_x, ex);
    chk("sr_y", obs_y, ey);
  endtask

  typedef struct {
    int          id;
    logic [31:0] t1, t2, ex, ey;
  } vec_t;
  vec_t tbl[6];

  int   got_ids[$];
  int   cnt, n;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; rr_m = 0;
    exp_t1 = '0; exp_t2 = '0; m_issued = 0; m_stall = 0; m_bp = 0;
    tbl[0] = '{0, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 32'h0000_0000};
    tbl[1] = '{1, 32'h0000_1000, 32'h0000_0200, 32'h0000_8E00, 32'h0000_1200};
    tbl[2] = '{0, 32'h0000_4000, 32'h0000_4000, 32'h0000_8000, 32'h0000_8000};
    tbl[3] = '{1, 32'hFFFF_8000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_8000};
    tbl[4] = '{0, 32'h0000_0000, 32'h0000_8000, 32'h0000_0000, 32'h0000_8000};
    tbl[5] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_7FFE, 32'h8000_0000};

    // Reset state, with requests pending during reset.
    rst = 1'b1; req_valid = '1; req_theta1 = '1; req_theta2 = '1; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_theta1", fk_theta1_o, 0);
    chk("rst_theta2", fk_theta2_o, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_x", resp_x, 0);
    chk("rst_resp_y", resp_y, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0; req_valid = '0; req_theta1 = '0; req_theta2 = '0;
    @(negedge clk);

    // Single requests from idle: fixed latency and datapath words.
    for (int i = 0; i < 6; i++)
      single_req(tbl[i].id, tbl[i].t1, tbl[i].t2, tbl[i].ex, tbl[i].ey);

    // Contention from rr_ptr = 0: grants alternate 0,1,0,1.
    do_reset();
    req_valid = 2'b11; resp_ready = 1'b1;
    req_theta1 = {32'h0000_0300, 32'h0000_0100};
    req_theta2 = {32'h0000_0030, 32'h0000_0010};
    for (int i = 0; i < 4; i++) begin
      cycle_check();
      chk("cont_grant", obs_ready, (i % 2) ? 2'b10 : 2'b01);
    end
    req_valid = '0;
    got_ids.delete();
    n = 0;
    while (got_ids.size() < 4 && n < 40) begin
      cycle_check();
      if (obs_rv) got_ids.push_back(int'(obs_id));
      n++;
    end
    chk("cont_count", got_ids.size(), 4);
    for (int i = 0; i < got_ids.size(); i++) chk("cont_order", got_ids[i], i % 2);
    drain();

    // Backpressure: exactly DEPTH issues, then release.
    resp_ready = 1'b0; req_valid = 2'b10;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      req_theta1[WIDTH +: WIDTH] = $urandom;
      req_theta2[WIDTH +: WIDTH] = $urandom;
      cycle_check();
      if (obs_hs) cnt++;
    end
    chk("bp_issues", cnt, DEPTH);
    chk("bp_ready_low", obs_ready, 0);
    resp_ready = 1'b1;
    n = 0; cnt = 0;
    do begin
      cycle_check();
      n++;
    end while (!obs_hs && n < 20);
    chk("bp_resumed", obs_hs, 1);
    drain();

    // Sustained stream with both requesters: pushes and pops overlap.
    resp_ready = 1'b1; req_valid = 2'b11;
    for (int i = 0; i < 40; i++) begin
      req_theta1 = {$urandom, $urandom};
      req_theta2 = {$urandom, $urandom};
      cycle_check();
    end
    drain();

    // Reset two cycles after three issues: nothing emerges afterwards.
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      req_theta1[0 +: WIDTH] = 32'h100 * (i + 1);
      cycle_check();
      chk("rst_mid_issue", obs_hs, 1);
    end
    req_valid = '0;
    cycle_check();
    cycle_check();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle_check();
      chk("rst_mid_no_resp", obs_rv, 0);
      chk("rst_mid_busy", obs_busy, 0);
    end
    single_req(tbl[0].id, tbl[0].t1, tbl[0].t2, tbl[0].ex, tbl[0].ey);

`ifdef FK_SCHED_PERF_EN
    // 4 issues, 3 stalls, drain, 2 more issues.
    do_reset();
    resp_ready = 1'b0; req_valid = 2'b01;
    repeat (7) cycle_check();
    drain();
    req_valid = 2'b01;
    repeat (2) cycle_check();
    drain();
    chk("perf_stall_total", perf_stall, 3);
    chk("perf_issued_total", perf_issued, 6);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      req_valid  = NREQ'($urandom);
      req_theta1 = {$urandom, $urandom};
      req_theta2 = {$urandom, $urandom};
      resp_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 299) == 0);
      cycle_check();
    end
    rst = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
